// File: rtl/filter_pkg.sv
// Shared types and constants for the filter grid sequencer: FSM states,
// pixel width, the tagged word sent to the grid and the default latency.
package filter_pkg;

    localparam int PIX_W            = 12;
    localparam int DEFAULT_PIPE_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VERT  = 2'd1,
        ST_HORZ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Edge tags ride above the pixel so the grid can clamp its kernel at borders.
    typedef struct packed {
        logic             y_edge;
        logic             x_edge;
        logic [PIX_W-1:0] pixel;
    } tagged_word_t;

endpackage

// File: rtl/filter_seq_if.sv
// Pixel stream, grid issue and status signals of filter_seq.
// master = pixel source / controller side, slave = filter_seq side.
interface filter_seq_if;
    import filter_pkg::*;

    logic             start;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    tagged_word_t     grid_data;
    logic             grid_vertical;
    logic             grid_en;
    logic             mag_valid;
    logic             frame_done;
    logic             busy;
    logic [15:0]      stall_cnt;

    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, grid_data, grid_vertical, grid_en,
               mag_valid, frame_done, busy, stall_cnt
    );

    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, grid_data, grid_vertical, grid_en,
               mag_valid, frame_done, busy, stall_cnt
    );

endinterface

// File: rtl/coord_counter.sv
// Raster column/row counter for the pixel stream; flags frame borders and
// the final pixel of the frame for the current (not yet accepted) position.
module coord_counter #(
    parameter int H_PIX = 640,
    parameter int V_PIX = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic x_edge,
    output logic y_edge,
    output logic last
);

    localparam int CW = $clog2(H_PIX);
    localparam int RW = $clog2(V_PIX);
    localparam logic [CW-1:0] COL_MAX = CW'(H_PIX - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_PIX - 1);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (advance) begin
            if (col_reg == COL_MAX) begin
                col_reg <= '0;
                row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign x_edge = (col_reg == '0) || (col_reg == COL_MAX);
    assign y_edge = (row_reg == '0) || (row_reg == ROW_MAX);
    assign last   = (col_reg == COL_MAX) && (row_reg == ROW_MAX);

endmodule

// File: rtl/filter_seq.sv
// Sequences each pixel through a vertical then a horizontal grid pass and
// tracks result latency; FILTER_SEQ_STALL_CNT_EN enables the stall counter.
module filter_seq
    import filter_pkg::*;
#(
    parameter int H_PIX    = 640,
    parameter int V_PIX    = 480,
    parameter int PIPE_LAT = DEFAULT_PIPE_LAT   // must be >= 1
) (
    input  logic         clk,
    input  logic         rst,
    filter_seq_if.slave  bus
);

    state_t       state_reg;
    logic         pix_ready_reg;
    logic         grid_en_reg;
    logic         grid_vertical_reg;
    tagged_word_t grid_data_reg;
    logic         last_pix_reg;

    logic [PIPE_LAT-1:0] mag_sr_reg;
    logic [PIPE_LAT-1:0] last_sr_reg;
    logic [PIPE_LAT-1:0] mag_sr_next;
    logic [PIPE_LAT-1:0] last_sr_next;

    logic start_accept;
    logic accept;
    logic h_issue;
    logic x_edge;
    logic y_edge;
    logic last_pix;

    assign start_accept = (state_reg == ST_IDLE) && bus.start;
    assign accept       = (state_reg == ST_VERT) && bus.pix_valid;
    assign h_issue      = grid_en_reg && !grid_vertical_reg;

    coord_counter #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_coord (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_accept),
        .advance (accept),
        .x_edge  (x_edge),
        .y_edge  (y_edge),
        .last    (last_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            pix_ready_reg     <= 1'b0;
            grid_en_reg       <= 1'b0;
            grid_vertical_reg <= 1'b0;
            grid_data_reg     <= '0;
            last_pix_reg      <= 1'b0;
        end else begin
            grid_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg     <= ST_VERT;
                        pix_ready_reg <= 1'b1;
                    end
                end
                ST_VERT: begin
                    if (accept) begin
                        state_reg         <= ST_HORZ;
                        pix_ready_reg     <= 1'b0;
                        grid_en_reg       <= 1'b1;
                        grid_vertical_reg <= 1'b1;
                        grid_data_reg     <= '{y_edge: y_edge, x_edge: x_edge, pixel: bus.pix_data};
                        last_pix_reg      <= last_pix;
                    end
                end
                ST_HORZ: begin
                    // Same word re-issued for the horizontal pass.
                    grid_en_reg       <= 1'b1;
                    grid_vertical_reg <= 1'b0;
                    state_reg         <= last_pix_reg ? ST_DRAIN : ST_VERT;
                    pix_ready_reg     <= !last_pix_reg;
                end
                ST_DRAIN: begin
                    if (last_sr_reg[PIPE_LAT-1]) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Horizontal issues travel down a latency line; a second line marks the
    // frame's final pixel so DRAIN ignores earlier results still in flight.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_lat
            if (gi == 0) begin : g_head
                assign mag_sr_next[gi]  = h_issue;
                assign last_sr_next[gi] = h_issue && (state_reg == ST_DRAIN);
            end else begin : g_body
                assign mag_sr_next[gi]  = mag_sr_reg[gi-1];
                assign last_sr_next[gi] = last_sr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_sr_reg  <= '0;
            last_sr_reg <= '0;
        end else begin
            mag_sr_reg  <= mag_sr_next;
            last_sr_reg <= last_sr_next;
        end
    end

`ifdef FILTER_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_VERT) && !bus.pix_valid && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

    assign bus.pix_ready     = pix_ready_reg;
    assign bus.grid_en       = grid_en_reg;
    assign bus.grid_vertical = grid_vertical_reg;
    assign bus.grid_data     = grid_data_reg;
    assign bus.mag_valid     = mag_sr_reg[PIPE_LAT-1];
    assign bus.frame_done    = last_sr_reg[PIPE_LAT-1];
    assign bus.busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_filter_seq.sv
// Randomized bench for filter_seq: a cycle-scheduled reference model predicts
// every output from the frame/pixel timing rules and is compared each cycle.
module tb_filter_seq;
    import filter_pkg::*;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int L   = 2;
    localparam int N   = H * V;
    localparam int FAR = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filter_seq_if bus();

    filter_seq #(
        .H_PIX    (H),
        .V_PIX    (V),
        .PIPE_LAT (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the frame is a window of busy cycles; each accepted pixel
    // schedules its two grid issues and its result at absolute cycle numbers.
    int          cyc;
    int          busy_from;
    int          busy_to;
    int          next_ok;
    int          idx;
    int          done_cycle;
    logic [13:0] g_data [int];
    bit          g_vert [int];
    bit          exp_mag [int];
    logic [13:0] m_last;
    logic [15:0] m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_tests++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp_val);
        end
    endtask

    function automatic bit m_busy(input int c);
        return (c >= busy_from) && (c < busy_to);
    endfunction

    function automatic bit m_ready(input int c);
        return m_busy(c) && (idx < N) && (c >= next_ok);
    endfunction

    // Check this cycle's outputs, drive this cycle's inputs, advance the model.
    task automatic step(input bit s, input bit v, input bit r, input logic [11:0] d);
        bit          rdy;
        bit          gen;
        int          col;
        int          row;
        logic [13:0] w;
        rdy = m_ready(cyc);
        gen = g_data.exists(cyc);
        if (gen) m_last = g_data[cyc];
        check("pix_ready", 32'(bus.pix_ready), 32'(rdy));
        check("busy", 32'(bus.busy), 32'(m_busy(cyc)));
        check("grid_en", 32'(bus.grid_en), 32'(gen));
        if (gen) check("grid_vertical", 32'(bus.grid_vertical), 32'(g_vert[cyc]));
        check("grid_data", 32'(bus.grid_data), 32'(m_last));
        check("mag_valid", 32'(bus.mag_valid), 32'(exp_mag.exists(cyc)));
        check("frame_done", 32'(bus.frame_done), 32'(cyc == done_cycle));
`ifdef FILTER_SEQ_STALL_CNT_EN
        check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
`else
        check("stall_cnt", 32'(bus.stall_cnt), 32'h0);
`endif
        rst           = r;
        bus.start     = s;
        bus.pix_valid = v;
        bus.pix_data  = d;
        if (r) begin
            busy_from  = 0;
            busy_to    = 0;
            idx        = 0;
            done_cycle = -1;
            g_data.delete();
            g_vert.delete();
            exp_mag.delete();
            m_last     = '0;
            m_stall    = '0;
        end else if (s && !m_busy(cyc)) begin
            busy_from = cyc + 1;
            busy_to   = FAR;
            next_ok   = cyc + 1;
            idx       = 0;
            m_stall   = '0;
        end else if (rdy) begin
            if (v) begin
                col = idx % H;
                row = idx / H;
                w   = {(row == 0 || row == V - 1), (col == 0 || col == H - 1), d};
                g_data[cyc + 1]     = w;
                g_vert[cyc + 1]     = 1'b1;
                g_data[cyc + 2]     = w;
                g_vert[cyc + 2]     = 1'b0;
                exp_mag[cyc + 2 + L] = 1'b1;
                if (idx == N - 1) begin
                    done_cycle = cyc + 2 + L;
                    busy_to    = cyc + 3 + L;
                end else begin
                    next_ok = cyc + 2;
                end
                idx++;
            end else if (m_stall != 16'hFFFF) begin
                m_stall = m_stall + 16'd1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_frame(input int k, input int pct, input int rst_at,
                             input int lead_stall, input logic [11:0] first_d);
        int          budget;
        int          accepted;
        bit          v;
        bit          s;
        bit          r;
        logic [11:0] d;
        step(1'b1, 1'b0, 1'b0, 12'h000);
        budget   = 0;
        accepted = 0;
        while (m_busy(cyc) && budget < 400) begin
            v = (budget < lead_stall) ? 1'b0 : ($urandom_range(0, 99) < pct);
            d = (idx == 0) ? first_d : 12'($urandom);
            s = ($urandom_range(0, 5) == 0);
            r = (rst_at >= 0) && (idx == rst_at);
            accepted = idx;
            step(s, v, r, d);
            budget++;
            if (r) break;
        end
        if (m_busy(cyc)) check("frame_timeout", 32'(m_busy(cyc)), 32'h0);
        $display("[TB] frame %0d: %0d pixels, %s at cycle %0d", k, accepted,
                 (rst_at >= 0) ? "reset" : "complete", cyc);
        repeat (3) step(1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        repeat (2) @(negedge clk);
        cyc        = 0;
        busy_from  = 0;
        busy_to    = 0;
        next_ok    = 0;
        idx        = 0;
        done_cycle = -1;
        m_last     = '0;
        m_stall    = '0;

        step(1'b0, 1'b0, 1'b1, 12'h000);
        step(1'b0, 1'b1, 1'b0, 12'h123);
        step(1'b0, 1'b0, 1'b0, 12'h000);

        run_frame(0, 100, -1, 0, 12'h0AB);
        run_frame(1, 100, -1, 5, 12'h5A5);
        run_frame(2, 100, 6, 0, 12'hFFF);
        run_frame(3, 100, -1, 0, 12'h001);
        for (int f = 4; f < 10; f++) begin
            run_frame(f, 60, -1, $urandom_range(0, 4), 12'($urandom));
        end
        run_frame(10, 75, $urandom_range(1, N - 1), 0, 12'($urandom));
        run_frame(11, 90, -1, 0, 12'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_seq.md
FILTER_SEQ -- requirements
Module: filter_seq

Interface
REQ-001 SHALL have parameter H_PIX, default 640, meaning pixels per row (min 2).
REQ-002 SHALL have parameter V_PIX, default 480, meaning rows per frame (min 2).
REQ-003 SHALL have parameter PIPE_LAT, default 2, meaning grid result latency in cycles after a horizontal issue.
REQ-004 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  begin a frame; sampled in IDLE only.
REQ-007 SHALL have port pix_valid  in  1  pixel offered.
REQ-008 SHALL have port pix_data  in  12  pixel value.
REQ-009 SHALL have port pix_ready  out  1  pixel accepted when high with pix_valid.
REQ-010 SHALL have port grid_data  out  14  {y_edge, x_edge, pixel[11:0]} to the filter grid.
REQ-011 SHALL have port grid_vertical  out  1  1 = vertical pass, 0 = horizontal pass.
REQ-012 SHALL have port grid_en  out  1  grid_data valid this cycle.
REQ-013 SHALL have port mag_valid  out  1  one-cycle pulse when one pixel's grid result is ready.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse at end of frame.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port stall_cnt  out  16  input stall count (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, VERT, HORZ, DRAIN.
REQ-018 IDLE: start=1 SHALL clear col/row to 0 and enter VERT next cycle.
REQ-019 VERT: pix_ready SHALL be 1; on pix_valid&pix_ready (cycle A) SHALL latch pixel and tags, enter HORZ.
REQ-020 Cycle A+1 (HORZ): grid_en=1, grid_vertical=1, pix_ready=0.
REQ-021 Cycle A+2: grid_en=1, grid_vertical=0, same grid_data; state VERT, or DRAIN if last pixel; pix_ready follows the new state.
REQ-022 Throughput SHALL be one pixel per 2 cycles maximum; grid_en SHALL be 0 in all other cycles.
REQ-023 x_edge SHALL be 1 iff col==0 or col==H_PIX-1; y_edge SHALL be 1 iff row==0 or row==V_PIX-1.
REQ-024 Col SHALL increment per accepted pixel, wrapping H_PIX-1 -> 0 with row+1; last pixel = (H_PIX-1, V_PIX-1).
REQ-025 mag_valid SHALL pulse PIPE_LAT cycles after each horizontal issue cycle (A+2+PIPE_LAT).
REQ-026 DRAIN SHALL hold until the last pixel's mag_valid cycle, pulse frame_done in that same cycle, then go to IDLE.
REQ-027 start outside IDLE SHALL be ignored; pix_valid while pix_ready=0 SHALL be neither accepted nor dropped (source holds).
REQ-028 grid_data SHALL hold its last value when grid_en=0.

Reset
REQ-029 rst SHALL force IDLE, col=row=0, and all outputs to 0 on the next edge, including mid-frame; pending mag_valid pulses SHALL be discarded.

Configuration
REQ-030 Macro FILTER_SEQ_STALL_CNT_EN defined: stall_cnt SHALL count cycles in VERT with pix_valid=0, saturate at 16'hFFFF, and clear on start accepted or rst.
REQ-031 Macro not defined: stall_cnt SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-032 Package filter_pkg SHALL hold the state enum, PIX_W=12, the 14-bit tagged-word typedef, and default PIPE_LAT.
REQ-033 Row/column counting and edge-flag generation SHALL be a sub-module coord_counter.

Verification (H_PIX=4, V_PIX=3, PIPE_LAT=2)
REQ-034 Pixel 12'h0AB accepted at cycle A: A+1 grid_data=14'h30AB (row 0, col 0), vertical=1; A+2 vertical=0; A+4 mag_valid=1.
REQ-035 Continuous pix_valid for 12 pixels: pix_ready alternates 1/0, col 1 gives x_edge=0, row 1 col 1 gives grid_data[13:12]=00, frame_done at last horizontal issue +2, busy drops the next cycle.
REQ-036 pix_valid held low 5 cycles in VERT with macro: stall_cnt=5; without macro: stall_cnt=0.
REQ-037 rst asserted after the 6th pixel: next cycle all outputs 0, state IDLE, no mag_valid afterwards; new start restarts at col 0, row 0.
REQ-038 start pulsed in VERT and HORZ: no effect on counters or state.
